// File: rtl/xy_motion_pkg.sv
// Shared types and default tuning constants for the two-axis move sequencer.
package xy_motion_pkg;

  localparam int DEF_W     = 26;
  localparam int DEF_STEPW = 16;
  localparam int DEF_SLOW  = 2500000;
  localparam int DEF_FAST  = 250000;
  localparam int DEF_DELTA = 50000;

  typedef enum logic [2:0] {
    IDLE,
    ACCEL,
    CRUISE,
    DECEL,
    DONE
  } axis_state_t;

endpackage

// File: rtl/axis_ramp.sv
// One axis of the move sequencer: step-edge detection, remaining/ramp counters
// and the accelerate/cruise/decelerate FSM that sets the divider half-period.
module axis_ramp
  import xy_motion_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int STEPW = DEF_STEPW,
  parameter int SLOW  = DEF_SLOW,
  parameter int FAST  = DEF_FAST,
  parameter int DELTA = DEF_DELTA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [STEPW-1:0] d,
  input  logic             abort,
  input  logic             clear,
  input  logic             clk_in,
  output logic [W-1:0]     speed,
  output logic             en,
  output logic             finished
);

  localparam logic [W:0] SLOW_X  = (W+1)'(SLOW);
  localparam logic [W:0] FAST_X  = (W+1)'(FAST);
  localparam logic [W:0] DELTA_X = (W+1)'(DELTA);

  axis_state_t      state, state_d;
  logic [STEPW-1:0] rem, rem_d;
  logic [STEPW-1:0] n, n_d;
  logic [W-1:0]     speed_d;
  logic             en_d;
  logic             clk_q;
  logic             step;

  logic [STEPW-1:0] rem_dec;
  logic [STEPW-1:0] n_dec;
  logic [W:0]       speed_up;
  logic [W:0]       speed_dn;

  assign step     = clk_in & ~clk_q;
  assign finished = (state == DONE);

  // Ramp arithmetic is one bit wider than the speed so neither direction wraps.
  always_comb begin
    rem_dec  = rem - 1'b1;
    n_dec    = (n == '0) ? '0 : n - 1'b1;
    speed_up = {1'b0, speed} + DELTA_X;
    if (speed_up > SLOW_X) speed_up = SLOW_X;
    speed_dn = ({1'b0, speed} >= FAST_X + DELTA_X) ? {1'b0, speed} - DELTA_X : FAST_X;
  end

  always_comb begin
    // NOTE: every next-state signal gets its default first, so no latch is inferred.
    state_d = state;
    rem_d   = rem;
    n_d     = n;
    speed_d = speed;
    en_d    = en;

    if (abort || clear) begin
      state_d = IDLE;
      speed_d = SLOW_X[W-1:0];
      en_d    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rem_d   = d;
            n_d     = '0;
            speed_d = SLOW_X[W-1:0];
            en_d    = (d != '0);
            state_d = (d != '0) ? ACCEL : DONE;
          end
        end
        ACCEL, CRUISE, DECEL: begin
          if (step) begin
            rem_d = rem_dec;
            if (rem_dec == '0) begin
              state_d = DONE;
              speed_d = SLOW_X[W-1:0];
              en_d    = 1'b0;
            end else if (state == DECEL || rem_dec <= n) begin
              // Enough steps left only to brake back down to SLOW.
              state_d = DECEL;
              speed_d = speed_up[W-1:0];
              n_d     = n_dec;
            end else if (state == ACCEL) begin
              speed_d = speed_dn[W-1:0];
              n_d     = n + 1'b1;
              if (speed_dn == FAST_X) state_d = CRUISE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      n     <= '0;
      speed <= SLOW_X[W-1:0];
      en    <= 1'b0;
      clk_q <= 1'b0;
    end else begin
      state <= state_d;
      rem   <= rem_d;
      n     <= n_d;
      speed <= speed_d;
      en    <= en_d;
      clk_q <= clk_in;
    end
  end

endmodule

// File: rtl/xy_motion_seq.sv
// Two-axis move sequencer: command handshake, direction latches, busy/done
// tracking and the join of the two axis ramps.
module xy_motion_seq
  import xy_motion_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int STEPW = DEF_STEPW,
  parameter int SLOW  = DEF_SLOW,
  parameter int FAST  = DEF_FAST,
  parameter int DELTA = DEF_DELTA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [STEPW-1:0] cmd_dx,
  input  logic [STEPW-1:0] cmd_dy,
  input  logic             cmd_dir_x,
  input  logic             cmd_dir_y,
  input  logic             abort,
  input  logic             clk_x_in,
  input  logic             clk_y_in,
  output logic [W-1:0]     speed_x,
  output logic [W-1:0]     speed_y,
  output logic             en_x,
  output logic             en_y,
  output logic             dir_x,
  output logic             dir_y,
  output logic             busy,
  output logic             done
);

  logic accept;
  logic abort_move;
  logic join_done;
  logic fin_x, fin_y;

  assign cmd_ready  = ~busy & ~abort;
  assign accept     = cmd_valid & cmd_ready;
  assign abort_move = abort & busy;
  assign join_done  = busy & fin_x & fin_y;

  axis_ramp #(.W(W), .STEPW(STEPW), .SLOW(SLOW), .FAST(FAST), .DELTA(DELTA)) u_axis_x (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .d        (cmd_dx),
    .abort    (abort_move),
    .clear    (join_done),
    .clk_in   (clk_x_in),
    .speed    (speed_x),
    .en       (en_x),
    .finished (fin_x)
  );

  axis_ramp #(.W(W), .STEPW(STEPW), .SLOW(SLOW), .FAST(FAST), .DELTA(DELTA)) u_axis_y (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .d        (cmd_dy),
    .abort    (abort_move),
    .clear    (join_done),
    .clk_in   (clk_y_in),
    .speed    (speed_y),
    .en       (en_y),
    .finished (fin_y)
  );

  // Abort wins over a completion landing in the same cycle: no done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      dir_x <= 1'b0;
      dir_y <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_move) begin
        busy <= 1'b0;
      end else if (join_done) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else if (accept) begin
        busy  <= 1'b1;
        dir_x <= cmd_dir_x;
        dir_y <= cmd_dir_y;
      end
    end
  end

endmodule

// File: tb/tb_xy_motion_seq.sv
// Directed bench for xy_motion_seq with a behavioural clock-divider model
// closing the loop from speed_* back to clk_*_in.
module tb_xy_motion_seq;
  import xy_motion_pkg::*;

  localparam int W = 26, STEPW = 16, SLOW = 10, FAST = 4, DELTA = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [STEPW-1:0] cmd_dx = '0, cmd_dy = '0;
  logic             cmd_dir_x = 1'b0, cmd_dir_y = 1'b0;
  logic             abort = 1'b0;
  logic             clk_x_in, clk_y_in;
  logic [W-1:0]     speed_x, speed_y;
  logic             en_x, en_y, dir_x, dir_y, busy, done;

  int vectors = 0;
  int miscompares = 0;
  int done_pulses = 0;

  logic [W-1:0] cnt_x, cnt_y;

  always #5 clk = ~clk;

  xy_motion_seq #(.W(W), .STEPW(STEPW), .SLOW(SLOW), .FAST(FAST), .DELTA(DELTA)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dx(cmd_dx), .cmd_dy(cmd_dy), .cmd_dir_x(cmd_dir_x), .cmd_dir_y(cmd_dir_y),
    .abort(abort), .clk_x_in(clk_x_in), .clk_y_in(clk_y_in),
    .speed_x(speed_x), .speed_y(speed_y), .en_x(en_x), .en_y(en_y),
    .dir_x(dir_x), .dir_y(dir_y), .busy(busy), .done(done)
  );

  // Divider model: toggles its output each time the count passes the half-period.
  always @(posedge clk) begin
    if (rst || !en_x) begin
      cnt_x <= '0; clk_x_in <= 1'b0;
    end else if (cnt_x >= speed_x) begin
      cnt_x <= '0; clk_x_in <= ~clk_x_in;
    end else begin
      cnt_x <= cnt_x + 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst || !en_y) begin
      cnt_y <= '0; clk_y_in <= 1'b0;
    end else if (cnt_y >= speed_y) begin
      cnt_y <= '0; clk_y_in <= ~clk_y_in;
    end else begin
      cnt_y <= cnt_y + 1'b1;
    end
  end

  always @(posedge clk) if (done) done_pulses <= done_pulses + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for the next rising edge of the chosen divided clock, then one more
  // cycle so the sequencer has applied its step update.
  task automatic wait_step(input bit axis_y, input string tag);
    int i;
    bit ok;
    i  = 0;
    ok = 1'b0;
    while (i < 200 && (axis_y ? clk_y_in : clk_x_in) === 1'b1) begin
      @(negedge clk); i++;
    end
    while (i < 200 && (axis_y ? clk_y_in : clk_x_in) !== 1'b1) begin
      @(negedge clk); i++;
    end
    if ((axis_y ? clk_y_in : clk_x_in) === 1'b1) ok = 1'b1;
    @(negedge clk);
    check({tag, "_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic send(input int dx, input int dy, input bit dxr, input bit dyr);
    cmd_dx    = STEPW'(dx);
    cmd_dy    = STEPW'(dy);
    cmd_dir_x = dxr;
    cmd_dir_y = dyr;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int trap[10];
    int tri4[4];
    int d0;
    trap = '{8, 6, 4, 4, 4, 4, 6, 8, 10, 10};
    tri4 = '{8, 6, 8, 10};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_speed_x", 32'(speed_x), 32'd10);
    check("rst_speed_y", 32'(speed_y), 32'd10);
    check("rst_en", {30'd0, en_x, en_y}, 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);

    // Reset in the middle of a move
    d0 = done_pulses;
    send(10, 6, 1'b1, 1'b1);
    wait_step(1'b0, "mid_x1");
    wait_step(1'b0, "mid_x2");
    check("mid_speed_x_pre", 32'(speed_x), 32'd6);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_speed_x", 32'(speed_x), 32'd10);
    check("mid_rst_speed_y", 32'(speed_y), 32'd10);
    check("mid_rst_en", {30'd0, en_x, en_y}, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_rst_no_done", 32'(done_pulses - d0), 32'd0);

    // Trapezoid on X only
    d0 = done_pulses;
    send(10, 0, 1'b1, 1'b0);
    check("trap_busy", 32'(busy), 32'd1);
    check("trap_ready", 32'(cmd_ready), 32'd0);
    check("trap_en", {30'd0, en_x, en_y}, 32'd2);
    check("trap_dir_x", 32'(dir_x), 32'd1);
    for (int k = 0; k < 10; k++) begin
      wait_step(1'b0, $sformatf("trap_s%0d", k + 1));
      check($sformatf("trap_speed_s%0d", k + 1), 32'(speed_x), 32'(trap[k]));
      if (k == 1) check("trap_accel_s2", 32'(dut.u_axis_x.state), 32'(ACCEL));
      if (k == 2) check("trap_cruise_s3", 32'(dut.u_axis_x.state), 32'(CRUISE));
      if (k == 5) check("trap_cruise_s6", 32'(dut.u_axis_x.state), 32'(CRUISE));
      if (k == 6) check("trap_decel_s7", 32'(dut.u_axis_x.state), 32'(DECEL));
    end
    check("trap_en_x_off", 32'(en_x), 32'd0);
    check("trap_done_early", 32'(done), 32'd0);
    @(negedge clk);
    check("trap_done", 32'(done), 32'd1);
    check("trap_busy_off", 32'(busy), 32'd0);
    @(negedge clk);
    check("trap_done_1cyc", 32'(done), 32'd0);
    check("trap_pulses", 32'(done_pulses - d0), 32'd1);

    // Triangle on X
    d0 = done_pulses;
    send(4, 0, 1'b0, 1'b1);
    check("tri_dir", {30'd0, dir_x, dir_y}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      wait_step(1'b0, $sformatf("tri_s%0d", k + 1));
      check($sformatf("tri_speed_s%0d", k + 1), 32'(speed_x), 32'(tri4[k]));
      if (k == 1) check("tri_accel_s2", 32'(dut.u_axis_x.state), 32'(ACCEL));
      if (k == 2) check("tri_decel_s3", 32'(dut.u_axis_x.state), 32'(DECEL));
    end
    repeat (3) @(negedge clk);
    check("tri_pulses", 32'(done_pulses - d0), 32'd1);

    // Both axes: X finishes first and waits for Y
    d0 = done_pulses;
    send(1, 3, 1'b1, 1'b0);
    check("both_en", {30'd0, en_x, en_y}, 32'd3);
    wait_step(1'b0, "both_x1");
    check("both_x_done_state", 32'(dut.u_axis_x.state), 32'(DONE));
    check("both_en_x_off", 32'(en_x), 32'd0);
    check("both_speed_y1", 32'(speed_y), 32'd8);
    check("both_busy_x1", 32'(busy), 32'd1);
    wait_step(1'b1, "both_y2");
    check("both_speed_y2", 32'(speed_y), 32'd10);
    check("both_no_done_y2", 32'(done_pulses - d0), 32'd0);
    wait_step(1'b1, "both_y3");
    check("both_done_early", 32'(done), 32'd0);
    @(negedge clk);
    check("both_done", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    check("both_pulses", 32'(done_pulses - d0), 32'd1);

    // Abort at X step 5; a command offered alongside abort is not taken
    d0 = done_pulses;
    send(10, 0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) wait_step(1'b0, $sformatf("abort_s%0d", k + 1));
    check("abort_speed_s5", 32'(speed_x), 32'd4);
    abort     = 1'b1;
    cmd_valid = 1'b1;
    cmd_dx    = STEPW'(3);
    #1;
    check("abort_ready_low", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_en_x", 32'(en_x), 32'd0);
    check("abort_speed_x", 32'(speed_x), 32'd10);
    check("abort_state", 32'(dut.u_axis_x.state), 32'(IDLE));
    abort     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("abort_no_accept", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done_pulses - d0), 32'd0);

    // Abort while idle does nothing
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort", {29'd0, busy, done, en_x}, 32'd0);

    // Zero move: done two cycles after accept
    d0 = done_pulses;
    send(0, 0, 1'b0, 1'b0);
    check("zero_busy", 32'(busy), 32'd1);
    check("zero_ready", 32'(cmd_ready), 32'd0);
    check("zero_done_c1", 32'(done), 32'd0);
    check("zero_en_c1", {30'd0, en_x, en_y}, 32'd0);
    @(negedge clk);
    check("zero_done_c2", 32'(done), 32'd1);
    check("zero_en_c2", {30'd0, en_x, en_y}, 32'd0);
    @(negedge clk);
    check("zero_done_c3", 32'(done), 32'd0);
    check("zero_pulses", 32'(done_pulses - d0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
